// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice walks WIDTH-bit operands LSB-first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             C
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   // Holds only the upper WIDTH-1 result bits; bit 0 falls out on the final shift.
   logic [WIDTH-2:0] r_s_sh;
   logic             r_cy;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_c;

   logic             w_s1;
   logic             w_c1;
   logic             w_bit;
   logic             w_c2;
   logic             w_cout;
   logic [WIDTH-1:0] w_s_next;
   logic [WIDTH-1:0] w_b_load;
   logic             w_cy_load;

   assign w_s1     = r_a_sh[0] ^ r_b_sh[0];
   assign w_c1     = r_a_sh[0] & r_b_sh[0];
   assign w_bit    = w_s1 ^ r_cy;
   assign w_c2     = w_s1 & r_cy;
   assign w_cout   = w_c1 | w_c2;
   assign w_s_next = {w_bit, r_s_sh};

`ifdef SERIAL_ADD_SUB_EN
   assign w_b_load  = sub ? ~B : B;
   assign w_cy_load = sub;
`else
   assign w_b_load  = B;
   assign w_cy_load = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_s_sh  <= '0;
         r_cy    <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_c     <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_a_sh  <= A;
                  r_b_sh  <= w_b_load;
                  r_cy    <= w_cy_load;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StRun;
               end
            end
            StRun: begin
               r_s_sh <= w_s_next[WIDTH-1:1];
               r_a_sh <= r_a_sh >> 1;
               r_b_sh <= r_b_sh >> 1;
               r_cy   <= w_cout;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_sum   <= w_s_next;
                  r_c     <= w_cout;
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end
            end
            StDone: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign Sum  = r_sum;
   assign C    = r_c;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl with a result scoreboard.
// Subtract cases run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sum;
   logic             C;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH:0]   sb[$];
   logic [WIDTH-1:0] prev_sum;
   logic             prev_c;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .C     (C)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: full-width add (or A + ~B + 1) with carry in bit WIDTH.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic s);
      logic [WIDTH:0] r;
      if (s) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      else   r = {1'b0, a} + {1'b0, b};
      return r;
   endfunction

   task automatic wait_done(input string tag, output int n);
      logic [WIDTH:0] e;
      n = 0;
      while (done !== 1'b1 && n < WIDTH + 4) begin
         check({tag, "_hold_sum"}, 32'(Sum), 32'(prev_sum));
         check({tag, "_hold_c"}, 32'(C), 32'(prev_c));
         tick();
         n++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (done === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_sum"}, 32'(Sum), 32'(e[WIDTH-1:0]));
         check({tag, "_c"}, 32'(C), 32'(e[WIDTH]));
         prev_sum = e[WIDTH-1:0];
         prev_c   = e[WIDTH];
      end
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s);
      int n;
      A = a;
      B = b;
`ifdef SERIAL_ADD_SUB_EN
      sub = s;
`endif
      start = 1'b1;
      sb.push_back(model(a, b, s));
      tick();
      start = 1'b0;
      A = ~a;
      B = ~b;
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      check({tag, "_done_run"}, 32'(done), 32'd0);
      wait_done(tag, n);
      check({tag, "_latency"}, 32'(n), 32'(WIDTH));
      tick();
      check({tag, "_done_fall"}, 32'(done), 32'd0);
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int seen;
      rst   = 1'b1;
      start = 1'b1;
      A     = 8'h12;
      B     = 8'h34;
`ifdef SERIAL_ADD_SUB_EN
      sub   = 1'b0;
`endif
      prev_sum = '0;
      prev_c   = 1'b0;

      // Reset with start held: reset must win.
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(Sum), 32'h00);
      check("rst_c", 32'(C), 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      tick();
      check("rst_idle_busy", 32'(busy), 32'd0);

      run_op("add_05_03", 8'h05, 8'h03, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
      run_op("add_aa_55", 8'hAA, 8'h55, 1'b0);

      // Start pulsed mid-RUN is ignored.
      A = 8'h10;
      B = 8'h20;
      start = 1'b1;
      sb.push_back(model(8'h10, 8'h20, 1'b0));
      tick();
      start = 1'b0;
      tick();
      tick();
      A = 8'hF0;
      B = 8'hF0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("ign", n);
      check("ign_latency", 32'(n + 3), 32'(WIDTH));
      seen = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         tick();
         if (done === 1'b1) seen++;
      end
      check("ign_single_done", 32'(seen), 32'd0);
      check("ign_sb_empty", 32'(sb.size()), 32'd0);

      // Held start: back-to-back results WIDTH+2 cycles apart.
      A = 8'h01;
      B = 8'h02;
      start = 1'b1;
      sb.push_back(model(8'h01, 8'h02, 1'b0));
      sb.push_back(model(8'h01, 8'h02, 1'b0));
      tick();
      wait_done("held1", n);
      check("held1_latency", 32'(n), 32'(WIDTH));
      tick();
      wait_done("held2", n);
      check("held_gap", 32'(n + 1), 32'(WIDTH + 2));
      start = 1'b0;
      tick();
      check("held_idle_busy", 32'(busy), 32'd0);

      // Abort mid-RUN.
      A = 8'h77;
      B = 8'h11;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prev_sum = '0;
      prev_c   = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(Sum), 32'h00);
      seen = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      check("abort_no_done", 32'(seen), 32'd0);
      check("abort_sum_hold", 32'(Sum), 32'h00);
      run_op("add_01_01", 8'h01, 8'h01, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      run_op("sub_05_07", 8'h05, 8'h07, 1'b1);
      run_op("sub_07_05", 8'h07, 8'h05, 1'b1);
      run_op("sub0_add", 8'h21, 8'h13, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
